vga_pixel_fetch: RTL and testbench

Pixel-fetch stage directly downstream of the VGA timing controller. Consumes the horizontal/vertical counters, sync, and active-area flag, and generates read addresses into an 8-bit grayscale framebuffer for an IMG_W × IMG_H window placed at (X0, Y0). Produces 8-bit R/G/B plus sync and blank signals that are pipeline-aligned to the returned pixel data, ready for the DAC.

---
 rtl/vga_pixel_fetch.sv | 150 +++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - framebuffer read-address generator and DAC-aligned pixel output stage
module vga_pixel_fetch #(
  parameter int          IMG_W   = 256,
  parameter int          IMG_H   = 256,
  parameter int          X0      = 192,
  parameter int          Y0      = 112,
  parameter int          ADDR_W  = 16,
  parameter int          MEM_LAT = 2,
  parameter logic [7:0]  BORDER  = 8'h00
) (
  input  logic              vgaclk,
  input  logic              rst,
  input  logic [9:0]        counter_H,
  input  logic [9:0]        counter_V,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out,
  output logic              frame_done
);

  localparam int DLY = MEM_LAT + 1;
  localparam logic [9:0] X_LO = 10'(X0);
  localparam logic [9:0] X_HI = 10'(X0 + IMG_W);
  localparam logic [9:0] Y_LO = 10'(Y0);
  localparam logic [9:0] Y_HI = 10'(Y0 + IMG_H);
  // One spare bit so the counter can park at IMG_W*IMG_H without wrapping.
  localparam logic [ADDR_W:0] CNT_END = (ADDR_W+1)'(IMG_W * IMG_H);
  localparam logic [ADDR_W:0] LAST_A  = (ADDR_W+1)'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  if (X0 + IMG_W > 640 || Y0 + IMG_H > 480) begin : g_bad_window
    $error("vga_pixel_fetch: window exceeds the 640x480 visible area");
  end
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("vga_pixel_fetch: MEM_LAT must be 1..4");
  end
  if (IMG_W * IMG_H > (1 << ADDR_W)) begin : g_bad_addr
    $error("vga_pixel_fetch: ADDR_W too small for the image");
  end

  typedef struct packed {
    logic last;
    logic win;
    logic blank;
    logic vsync;
    logic hsync;
  } tap_t;

  typedef struct packed {
    logic [7:0] pix;
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic       done;
  } out_t;

  localparam tap_t TAP_IDLE = tap_t'(5'b00011);
  localparam out_t OUT_IDLE = out_t'({8'h00, 4'b1100});

  logic              frame_start, in_win, win, last;
  logic [ADDR_W:0]   issue_cnt;
  logic              armed_q, armed_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rd_en_q, rd_en_d;
  tap_t              tap_q [DLY];
  tap_t              tap_d [DLY];
  tap_t              tap_o;
  out_t              out_q, out_d;

  always_comb begin
    frame_start = (counter_H == 10'd0) && (counter_V == 10'd0);
    in_win      = (counter_H >= X_LO) && (counter_H < X_HI) &&
                  (counter_V >= Y_LO) && (counter_V < Y_HI) && blank_in;
    // A frame start arms the fetcher in the same cycle, so X0=Y0=0 still reads pixel 0.
    win         = in_win && (armed_q || frame_start);
    issue_cnt   = frame_start ? '0 : cnt_q;
    last        = (issue_cnt == LAST_A);

    armed_d = armed_q || frame_start;
    cnt_d   = issue_cnt;
    if (win && issue_cnt != CNT_END) begin
      cnt_d = issue_cnt + CNT_ONE;
    end

    mem_addr_d = win ? issue_cnt[ADDR_W-1:0] : mem_addr_q;
    rd_en_d    = win;

    tap_d[0] = '{last: last, win: win, blank: blank_in, vsync: vsync_in, hsync: hsync_in};
    for (int i = 1; i < DLY; i++) begin
      tap_d[i] = tap_q[i-1];
    end

    tap_o       = tap_q[DLY-1];
    out_d       = OUT_IDLE;
    out_d.hsync = tap_o.hsync;
    out_d.vsync = tap_o.vsync;
    out_d.blank = tap_o.blank;
    out_d.done  = tap_o.last && tap_o.win;
    if (!tap_o.blank) begin
      out_d.pix = 8'h00;
    end else if (tap_o.win) begin
      out_d.pix = mem_data;
    end else begin
      out_d.pix = BORDER;
    end
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      rd_en_q    <= 1'b0;
      for (int i = 0; i < DLY; i++) begin
        tap_q[i] <= TAP_IDLE;
      end
      out_q      <= OUT_IDLE;
    end else begin
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      rd_en_q    <= rd_en_d;
      for (int i = 0; i < DLY; i++) begin
        tap_q[i] <= tap_d[i];
      end
      out_q      <= out_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd_en  = rd_en_q;
  assign vga_r      = out_q.pix;
  assign vga_g      = out_q.pix;
  assign vga_b      = out_q.pix;
  assign hsync_out  = out_q.hsync;
  assign vsync_out  = out_q.vsync;
  assign blank_out  = out_q.blank;
  assign frame_done = out_q.done;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - three latency variants against a pixel-index reference model
module tb_vga_pixel_fetch;

  localparam int         W = 256, H = 4, X0 = 192, Y0 = 112, AW = 10, TOT = W * H;
  localparam logic [7:0] BORDER = 8'h5A;
  localparam int         NI = 3;

  logic vgaclk = 1'b0;
  always #5 vgaclk = ~vgaclk;

  logic          rst;
  logic [9:0]    counter_H, counter_V;
  logic          hsync_in, vsync_in, blank_in;
  logic [AW-1:0] mem_addr [NI];
  logic          mem_rd_en [NI];
  logic [7:0]    mem_data [NI];
  logic [7:0]    vga_r [NI], vga_g [NI], vga_b [NI];
  logic          hsync_out [NI], vsync_out [NI], blank_out [NI], frame_done [NI];
  logic [7:0]    fb [TOT];

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [7:0] mdq [4];

    vga_pixel_fetch #(
      .IMG_W(W), .IMG_H(H), .X0(X0), .Y0(Y0), .ADDR_W(AW), .MEM_LAT(L), .BORDER(BORDER)
    ) dut (
      .vgaclk(vgaclk), .rst(rst), .counter_H(counter_H), .counter_V(counter_V),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
      .mem_addr(mem_addr[g]), .mem_rd_en(mem_rd_en[g]), .mem_data(mem_data[g]),
      .vga_r(vga_r[g]), .vga_g(vga_g[g]), .vga_b(vga_b[g]),
      .hsync_out(hsync_out[g]), .vsync_out(vsync_out[g]), .blank_out(blank_out[g]),
      .frame_done(frame_done[g])
    );

    always @(posedge vgaclk) begin
      mdq[0] <= mem_rd_en[g] ? fb[mem_addr[g]] : 8'h00;
      for (int i = 1; i < 4; i++) mdq[i] <= mdq[i-1];
    end
    assign mem_data[g] = mdq[L-1];
  end

  int            checks = 0, errors = 0, cyc = 8, fd_exp = 0;
  int            fd_seen [NI];
  bit            armed_m = 0;
  logic [AW-1:0] exp_addr = '0;
  bit            exp_en = 0;
  bit            h_rst [8];
  logic [27:0]   h_tup [8];

  task automatic fill_fb();
    for (int i = 0; i < TOT; i++) fb[i] = 8'($urandom);
  endtask

  task automatic step(input int h, input int v, input bit r);
    bit fs, inw, win, hs, vs, bl;
    int idx;
    logic [7:0]  pix;
    logic [27:0] tup, exp_o, obs;
    bit any_r;
    int L;
    hs = !(h >= 656 && h < 752);
    vs = !(v >= 490 && v < 492);
    bl = (h < 640) && (v < 480);
    counter_H = 10'(h); counter_V = 10'(v);
    hsync_in = hs; vsync_in = vs; blank_in = bl; rst = r;
    @(posedge vgaclk);
    fs  = (h == 0) && (v == 0);
    inw = (h >= X0) && (h < X0 + W) && (v >= Y0) && (v < Y0 + H) && bl;
    win = inw && !r && (armed_m || fs);
    armed_m = r ? 1'b0 : (fs ? 1'b1 : armed_m);
    idx = (v - Y0) * W + (h - X0);
    pix = !bl ? 8'h00 : (win ? fb[idx] : BORDER);
    tup = {pix, pix, pix, hs, vs, bl, (win && idx == TOT - 1)};
    if (tup[0]) fd_exp++;
    h_rst[cyc % 8] = r;
    h_tup[cyc % 8] = tup;
    if (r) exp_addr = '0;
    else if (win) exp_addr = AW'(idx);
    exp_en = win;
    #1;
    for (int g = 0; g < NI; g++) begin
      L = lat_of(g);
      any_r = 0;
      for (int j = 0; j <= L + 1; j++) any_r |= h_rst[(cyc - j) % 8];
      exp_o = any_r ? {24'h0, 4'b1100} : h_tup[(cyc - L - 1) % 8];
      obs = {vga_r[g], vga_g[g], vga_b[g], hsync_out[g], vsync_out[g], blank_out[g], frame_done[g]};
      checks++;
      assert (obs === exp_o) else begin
        errors++;
        $error("FAIL out lat=%0d H=%0d V=%0d observed=%h expected=%h", L, h, v, obs, exp_o);
      end
      checks++;
      assert ({mem_rd_en[g], mem_addr[g]} === {exp_en, exp_addr}) else begin
        errors++;
        $error("FAIL mem lat=%0d H=%0d V=%0d observed=%b/%0d expected=%b/%0d",
               L, h, v, mem_rd_en[g], mem_addr[g], exp_en, exp_addr);
      end
      if (frame_done[g] === 1'b1) fd_seen[g]++;
    end
    cyc++;
  endtask

  task automatic run_row(input int v, input int rst_v, input int rst_k);
    int hl[$];
    hl = '{0, 1, 100};
    if (v >= Y0 && v < Y0 + H) begin
      for (int h = X0 - 3; h <= X0 + W + 2; h++) hl.push_back(h);
    end else begin
      hl.push_back(191); hl.push_back(192); hl.push_back(197);
      hl.push_back(447); hl.push_back(448);
    end
    foreach (hl[k]) ;
    hl.push_back(638); hl.push_back(639); hl.push_back(640); hl.push_back(641);
    hl.push_back(655); hl.push_back(656); hl.push_back(657); hl.push_back(751);
    hl.push_back(752); hl.push_back(798); hl.push_back(799);
    for (int k = 0; k < 2; k++) hl.push_back($urandom_range(640, 799));
    foreach (hl[k]) step(hl[k], v, (v == rst_v) && (k >= rst_k) && (k < rst_k + 3));
  endtask

  task automatic run_frame(input int v_from, input int rst_v, input int rst_k);
    int vl[$];
    vl = '{0, 1, 2, 3, 100, 101, 110, 111, 112, 113, 114, 115, 116, 117, 200, 300,
           367, 368, 479, 480, 481, 489, 490, 491, 492, 500, 524};
    foreach (vl[i]) if (vl[i] >= v_from) run_row(vl[i], rst_v, rst_k);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin h_rst[i] = 1'b1; h_tup[i] = '0; end
    for (int g = 0; g < NI; g++) fd_seen[g] = 0;
    fill_fb();
    for (int i = 0; i < 3; i++) step(10 + i, 20, 1'b1);
    run_frame($urandom_range(150, 340), -1, 0);
    fill_fb(); run_frame(0, -1, 0);
    fill_fb(); run_frame(0, -1, 0);
    fill_fb(); run_frame(0, 300, $urandom_range(2, 10));
    fill_fb(); run_frame(0, 113, $urandom_range(20, 200));
    fill_fb(); run_frame(0, -1, 0);
    for (int i = 0; i < 8; i++) step(2 + i, 0, 1'b0);
    for (int g = 0; g < NI; g++) begin
      checks++;
      assert (fd_seen[g] == fd_exp && fd_exp == 4) else begin
        errors++;
        $error("FAIL frame_done_count lat=%0d observed=%0d expected=%0d", lat_of(g), fd_seen[g], 4);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
